// File: rtl/imem_responder.sv
// Instruction-memory responder: fixed-latency ROM read pipeline with a credit-limited response FIFO.
// Define IMEM_ERR_CHECK_EN to fault misaligned or out-of-window fetches.
module imem_responder #(
    parameter int          AWIDTH      = 32,
    parameter int          DWIDTH      = 32,
    parameter logic [31:0] BASE_ADDR   = 32'h0100_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2,
    parameter int          QDEPTH      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [AWIDTH-1:0] req_addr_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [AWIDTH-1:0] rsp_addr_o,
    output logic [DWIDTH-1:0] rsp_data_o,
    output logic              rsp_err_o
);

    localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int QW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH + 1);
    localparam logic [AWIDTH-1:0] BASE_A = AWIDTH'(BASE_ADDR);

    // Word i holds an "addi"-shaped pattern carrying its own index; word 0 is a plain nop.
    function automatic logic [DWIDTH-1:0] init_word(input int unsigned idx);
        init_word = (DWIDTH'(idx) << 7) | DWIDTH'(32'h0000_0013);
    endfunction

    function automatic logic [QW-1:0] ptr_inc(input logic [QW-1:0] ptr);
        ptr_inc = (ptr == QW'(QDEPTH - 1)) ? {QW{1'b0}} : ptr + QW'(1);
    endfunction

    logic [DWIDTH-1:0] rom [DEPTH_WORDS];

    for (genvar g = 0; g < DEPTH_WORDS; g++) begin : g_rom
        assign rom[g] = init_word(g);
    end

    logic              accept_s;
    logic              pop_s;
    logic              final_valid_s;
    logic [AWIDTH-1:0] final_addr_s;
    logic [IW-1:0]     word_index_s;
    logic [DWIDTH-1:0] rom_word_s;
    logic              fault_s;

    logic [CW-1:0]     outstanding_r;
    logic [CW-1:0]     fifo_count_r;
    logic [QW-1:0]     wr_ptr_r;
    logic [QW-1:0]     rd_ptr_r;
    logic [AWIDTH-1:0] fifo_addr_r [QDEPTH];
    logic [DWIDTH-1:0] fifo_data_r [QDEPTH];
    logic              fifo_err_r  [QDEPTH];

    // Ready and valid are gated by rst so both read 0 throughout reset, including its first cycle.
    assign req_ready_o = !rst && (outstanding_r < CW'(QDEPTH));
    assign rsp_valid_o = !rst && (fifo_count_r != {CW{1'b0}});
    assign accept_s    = req_valid_i && req_ready_o;
    assign pop_s       = rsp_valid_o && rsp_ready_i;

    assign rsp_addr_o  = rsp_valid_o ? fifo_addr_r[rd_ptr_r] : {AWIDTH{1'b0}};
    assign rsp_data_o  = rsp_valid_o ? fifo_data_r[rd_ptr_r] : {DWIDTH{1'b0}};
    assign rsp_err_o   = rsp_valid_o ? fifo_err_r[rd_ptr_r]  : 1'b0;

    if (LATENCY == 1) begin : g_lat1
        assign final_valid_s = accept_s;
        assign final_addr_s  = req_addr_i;
    end else begin : g_pipe
        logic              pipe_valid_r [LATENCY-1];
        logic [AWIDTH-1:0] pipe_addr_r  [LATENCY-1];

        // Request pipeline: always advances, since the credit limit keeps the FIFO from filling.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < LATENCY - 1; i++) begin
                    pipe_valid_r[i] <= 1'b0;
                end
            end else begin
                pipe_valid_r[0] <= accept_s;
                pipe_addr_r[0]  <= req_addr_i;
                for (int i = 1; i < LATENCY - 1; i++) begin
                    pipe_valid_r[i] <= pipe_valid_r[i-1];
                    pipe_addr_r[i]  <= pipe_addr_r[i-1];
                end
            end
        end

        assign final_valid_s = pipe_valid_r[LATENCY-2];
        assign final_addr_s  = pipe_addr_r[LATENCY-2];
    end

    // ROM lookup and fault classification for the request leaving the pipeline.
    always_comb begin
        word_index_s = IW'((final_addr_s - BASE_A) >> 2);
        rom_word_s   = rom[word_index_s];
`ifdef IMEM_ERR_CHECK_EN
        fault_s = (final_addr_s[1:0] != 2'b00)
               || ({1'b0, final_addr_s} < {1'b0, BASE_A})
               || ({1'b0, final_addr_s} >= ({1'b0, BASE_A} + (AWIDTH+1)'(4 * DEPTH_WORDS)));
`else
        fault_s = 1'b0;
`endif
    end

    // Response FIFO plus the outstanding-request credit counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r      <= {QW{1'b0}};
            rd_ptr_r      <= {QW{1'b0}};
            fifo_count_r  <= {CW{1'b0}};
            outstanding_r <= {CW{1'b0}};
        end else begin
            if (final_valid_s) begin
                fifo_addr_r[wr_ptr_r] <= final_addr_s;
                fifo_data_r[wr_ptr_r] <= fault_s ? {DWIDTH{1'b0}} : rom_word_s;
                fifo_err_r[wr_ptr_r]  <= fault_s;
                wr_ptr_r              <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({final_valid_s, pop_s})
                2'b10:   fifo_count_r <= fifo_count_r + CW'(1);
                2'b01:   fifo_count_r <= fifo_count_r - CW'(1);
                default: fifo_count_r <= fifo_count_r;
            endcase
            case ({accept_s, pop_s})
                2'b10:   outstanding_r <= outstanding_r + CW'(1);
                2'b01:   outstanding_r <= outstanding_r - CW'(1);
                default: outstanding_r <= outstanding_r;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// Directed and short random bench for imem_responder with an in-order response scoreboard.
module tb_imem_responder;

    localparam int          LAT  = 2;
    localparam logic [31:0] BASE = 32'h0100_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] req_addr_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_addr_o;
    logic [31:0] rsp_data_o;
    logic        rsp_err_o;

    imem_responder dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_addr_i  (req_addr_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_addr_o  (rsp_addr_o),
        .rsp_data_o  (rsp_data_o),
        .rsp_err_o   (rsp_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
        int          due;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad = 0;
    int   cycle = 0;
    int   accepts = 0;
    int   pops = 0;
    bit   lat_mode = 1'b0;

    always @(posedge clk) cycle <= cycle + 1;

    function automatic exp_t model(input logic [31:0] a, input int due);
        exp_t        e;
        logic [31:0] off;
        off    = a - BASE;
        e.addr = a;
        e.data = ({22'd0, off[11:2]} << 7) | 32'h0000_0013;
        e.err  = 1'b0;
`ifdef IMEM_ERR_CHECK_EN
        if (a[1:0] != 2'b00 || a < BASE || a >= BASE + 32'h0000_1000) begin
            e.data = 32'h0;
            e.err  = 1'b1;
        end
`endif
        e.due = due;
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: push on accept, pop and compare on consume.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sbq.delete();
        end else begin
            if (req_valid_i && req_ready_o) begin
                sbq.push_back(model(req_addr_i, lat_mode ? cycle + LAT : -1));
                accepts++;
            end
            if (rsp_valid_o && rsp_ready_i) begin
                pops++;
                total++;
                assert (sbq.size() > 0) else begin
                    bad++;
                    $error("FAIL spurious_rsp observed addr=%0h expected no response", rsp_addr_o);
                end
                if (sbq.size() > 0) begin
                    e = sbq.pop_front();
                    check("rsp_addr", rsp_addr_o, e.addr);
                    check("rsp_data", rsp_data_o, e.data);
                    check("rsp_err", rsp_err_o, e.err);
                    if (e.due >= 0) check("rsp_latency", cycle, e.due);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          p0;
        int          a0;
        int          n;
        logic [31:0] a;
        logic        took;
        logic [31:0] h_addr;
        logic [31:0] h_data;
        logic        h_err;
        logic [31:0] edge_addrs [4];

        rst = 1'b1; req_valid_i = 1'b1; req_addr_i = BASE; rsp_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", req_ready_o, 1'b0);
        check("rst_rsp_valid", rsp_valid_o, 1'b0);
        check("rst_rsp_addr", rsp_addr_o, 32'h0);
        check("rst_rsp_data", rsp_data_o, 32'h0);
        check("rst_rsp_err", rsp_err_o, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0; req_valid_i = 1'b0; rsp_ready_i = 1'b0;
        @(negedge clk);
        check("ready_after_rst", req_ready_o, 1'b1);

        // Single fetch of word 0 and its exact latency.
        @(posedge clk); #1;
        lat_mode = 1'b1; rsp_ready_i = 1'b1; req_valid_i = 1'b1; req_addr_i = BASE;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        @(negedge clk);
        check("lat_early_valid", rsp_valid_o, 1'b0);
        @(negedge clk);
        check("lat_valid", rsp_valid_o, 1'b1);
        check("word0_data", rsp_data_o, 32'h0000_0013);
        check("word0_err", rsp_err_o, 1'b0);
        repeat (2) @(posedge clk); #1;

        // Back-to-back stream of eight fetches.
        p0 = pops;
        for (int i = 0; i < 8; i++) begin
            req_valid_i = 1'b1;
            req_addr_i  = BASE + 32'(4 * i);
            @(negedge clk);
            check("b2b_ready", req_ready_o, 1'b1);
            @(posedge clk); #1;
        end
        req_valid_i = 1'b0;
        repeat (LAT + 2) @(posedge clk); #1;
        check("b2b_count", pops - p0, 8);
        lat_mode = 1'b0;

        // Backpressure: six offered, four credits.
        rsp_ready_i = 1'b0; a0 = accepts; p0 = pops; a = BASE + 32'h40;
        for (int i = 0; i < 6; i++) begin
            req_valid_i = 1'b1;
            req_addr_i  = a;
            @(negedge clk);
            took = req_ready_o;
            @(posedge clk); #1;
            if (took) a = a + 32'd4;
        end
        req_valid_i = 1'b0;
        check("stall_accepts", accepts - a0, 4);
        @(negedge clk);
        check("stall_ready_low", req_ready_o, 1'b0);
        check("stall_valid", rsp_valid_o, 1'b1);
        h_addr = rsp_addr_o; h_data = rsp_data_o; h_err = rsp_err_o;
        repeat (3) @(negedge clk);
        check("stall_hold_valid", rsp_valid_o, 1'b1);
        check("stall_hold_addr", rsp_addr_o, h_addr);
        check("stall_hold_data", rsp_data_o, h_data);
        check("stall_hold_err", rsp_err_o, h_err);
        @(posedge clk); #1;
        rsp_ready_i = 1'b1;
        n = 0;
        while (sbq.size() != 0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("stall_drain_empty", sbq.size(), 0);
        check("stall_rsp_count", pops - p0, 4);

        // Window edges, wrap and misalignment.
        edge_addrs[0] = 32'h0100_1000; edge_addrs[1] = 32'h0100_0002;
        edge_addrs[2] = 32'h00FF_FFFC; edge_addrs[3] = 32'h0100_0FFC;
        p0 = pops;
        for (int i = 0; i < 4; i++) begin
            req_valid_i = 1'b1;
            req_addr_i  = edge_addrs[i];
            @(posedge clk); #1;
        end
        req_valid_i = 1'b0;
        repeat (LAT + 2) @(posedge clk); #1;
        check("edge_rsp_count", pops - p0, 4);

        // Reset with three requests in flight.
        rsp_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_valid_i = 1'b1;
            req_addr_i  = BASE + 32'(8 * i);
            @(posedge clk); #1;
        end
        req_valid_i = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_valid", rsp_valid_o, 1'b0);
        check("mid_rst_ready", req_ready_o, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0; rsp_ready_i = 1'b1;
        p0 = pops;
        @(negedge clk);
        check("ready_after_pulse", req_ready_o, 1'b1);
        repeat (8) @(negedge clk);
        check("no_rsp_after_rst", pops - p0, 0);

        // Short random traffic with random backpressure.
        @(posedge clk); #1;
        for (int i = 0; i < 80; i++) begin
            req_valid_i = 1'($urandom_range(0, 1));
            req_addr_i  = BASE + 32'(4 * $urandom_range(0, 1023));
            rsp_ready_i = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        req_valid_i = 1'b0; rsp_ready_i = 1'b1;
        n = 0;
        while (sbq.size() != 0 && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        check("final_drain_empty", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 SHALL have parameter AWIDTH, default 32, address width.
REQ-002 SHALL have parameter DWIDTH, default 32, instruction word width.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h0100_0000, byte address of word 0.
REQ-004 SHALL have parameter DEPTH_WORDS, default 1024, number of words stored; power of two.
REQ-005 SHALL have parameter LATENCY, default 2, accept-to-response cycles; legal range 1..4.
REQ-006 SHALL have parameter QDEPTH, default 4, maximum outstanding requests; QDEPTH >= LATENCY+1.
REQ-007 SHALL have port clk  input  1  clock; all state on rising edge.
REQ-008 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-009 SHALL have port req_valid_i  input  1  fetch request present.
REQ-010 SHALL have port req_ready_o  output  1  request can be accepted this cycle.
REQ-011 SHALL have port req_addr_i  input  AWIDTH  requested byte address (pc).
REQ-012 SHALL have port rsp_valid_o  output  1  response present.
REQ-013 SHALL have port rsp_ready_i  input  1  requester consumes response.
REQ-014 SHALL have port rsp_addr_o  output  AWIDTH  address of the request being answered.
REQ-015 SHALL have port rsp_data_o  output  DWIDTH  instruction word.
REQ-016 SHALL have port rsp_err_o  output  1  address fault for this response.

Function
REQ-017 SHALL accept a request on a cycle where req_valid_i and req_ready_o are both 1; otherwise no request is taken.
REQ-018 SHALL drive req_ready_o = 1 exactly when outstanding count (accepted, not yet consumed) < QDEPTH and not in reset.
REQ-019 SHALL compute word index = (req_addr_i - BASE_ADDR) >> 2, truncated to log2(DEPTH_WORDS) bits.
REQ-020 SHALL carry each accepted request through a LATENCY-stage valid/addr pipeline, reading the word array in the stage's final cycle.
REQ-021 SHALL write each pipeline output into a QDEPTH-entry response FIFO; credit rule of REQ-018 guarantees the FIFO never overflows.
REQ-022 SHALL drive rsp_valid_o from FIFO non-empty; with an empty FIFO and rsp_ready_i = 1, response appears exactly LATENCY cycles after acceptance.
REQ-023 SHALL hold rsp_valid_o, rsp_addr_o, rsp_data_o, rsp_err_o stable while rsp_valid_o = 1 and rsp_ready_i = 0.
REQ-024 SHALL pop one FIFO entry on a cycle where rsp_valid_o and rsp_ready_i are both 1.
REQ-025 SHALL return responses in acceptance order.
REQ-026 SHALL leave outstanding count unchanged on a cycle with both an accept and a pop; +1 for accept only; -1 for pop only.
REQ-027 SHALL sustain one accept per cycle indefinitely when rsp_ready_i is held 1.
REQ-028 SHALL never modify the word array; array contents are loaded at elaboration and unaffected by rst.
REQ-029 SHALL drive rsp_data_o = 0 and rsp_err_o = 0 while rsp_valid_o = 0.

Reset
REQ-030 SHALL, while rst = 1, clear all pipeline valids, empty the FIFO, clear outstanding count, and drive req_ready_o = 0, rsp_valid_o = 0, rsp_addr_o = 0, rsp_data_o = 0, rsp_err_o = 0.
REQ-031 SHALL discard all in-flight and queued requests when rst asserts mid-operation; none is ever returned.
REQ-032 SHALL drive req_ready_o = 1 on the first cycle after rst deasserts.

Configuration
REQ-033 SHALL, with macro IMEM_ERR_CHECK_EN defined, flag rsp_err_o = 1 and return rsp_data_o = 0 when address[1:0] != 0, address < BASE_ADDR, or address >= BASE_ADDR + 4*DEPTH_WORDS.
REQ-034 SHALL, without IMEM_ERR_CHECK_EN, hold rsp_err_o = 0 permanently and read the truncated index of REQ-019 (wrap modulo DEPTH_WORDS, low two address bits ignored).

Verification
REQ-035 SHALL cover: word 0 = 32'h0000_0013, request 32'h0100_0000, rsp_ready_i = 1 -> rsp_valid_o 2 cycles later, data 32'h0000_0013, err 0.
REQ-036 SHALL cover: back-to-back requests 0x0100_0000..0x0100_001C, rsp_ready_i = 1 -> 8 in-order responses on 8 consecutive cycles, req_ready_o never 0.
REQ-037 SHALL cover: rsp_ready_i = 0, 6 requests offered -> exactly 4 accepted, req_ready_o = 0 thereafter; rsp_ready_i = 1 -> 4 responses, stable while stalled.
REQ-038 SHALL cover (IMEM_ERR_CHECK_EN): requests 0x0100_0002, 0x00FF_FFFC, 0x0100_1000 -> each err 1, data 0; without macro 0x0100_1000 returns word 0, err 0.
REQ-039 SHALL cover: 3 requests outstanding, rst pulsed 1 cycle -> no responses ever emitted, req_ready_o = 1 on the cycle after rst falls.
